// File: rtl/debug_sequencer.sv
// Debug-port sequencer: takes one host command at a time, requests debug mode from the core,
// drives the command's one- or two-cycle control-word sequence, then releases the core and responds.
module debug_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [2:0] cmd_op_i,
  input  logic [3:0] cmd_addr_i,
  input  logic [7:0] cmd_data_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       busy_o,
  output logic       debug_request_o,
  input  logic       debug_ack_i,
  output logic [7:0] debug_data_o,
  input  logic [7:0] bus_i,
  output logic       d_clr_o,
  output logic       d_hlt_o,
  output logic       d_ce_o,
  output logic       d_su_o,
  output logic       d_ri_o,
  output logic       d_ai_n_o,
  output logic       d_bi_n_o,
  output logic       d_oi_n_o,
  output logic       d_ii_n_o,
  output logic       d_j_n_o,
  output logic       d_fi_n_o,
  output logic       d_mi_n_o,
  output logic       d_do_n_o,
  output logic       d_ao_n_o,
  output logic       d_bo_n_o,
  output logic       d_io_n_o,
  output logic       d_co_n_o,
  output logic       d_eo_n_o,
  output logic       d_ro_n_o,
  output logic       d_no_n_o
);

  // state   | meaning
  // IDLE    | ready for a command, idle control word
  // REQ     | debug request raised, waiting for ack or timeout
  // STEP1   | first control word of the command
  // STEP2   | second control word (memory ops only)
  // RELEASE | request dropped, waiting for ack to fall
  // RSP     | response valid until consumed
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    STEP1   = 3'd2,
    STEP2   = 3'd3,
    RELEASE = 3'd4,
    RSP     = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_WR_MEM  = 3'd0,
    OP_RD_MEM  = 3'd1,
    OP_SET_PC  = 3'd2,
    OP_RD_A    = 3'd3,
    OP_RD_B    = 3'd4,
    OP_RD_PC   = 3'd5,
    OP_WR_A    = 3'd6,
    OP_CLR_CPU = 3'd7
  } op_e;

  localparam logic [15:0] ACK_TC = 16'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic [3:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= OP_WR_MEM;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    addr_d          = addr_q;
    data_d          = data_q;
    cnt_d           = cnt_q;
    rsp_data_d      = rsp_data_q;
    rsp_err_d       = rsp_err_q;
    debug_request_o = 1'b0;
    debug_data_o    = 8'h00;
    d_clr_o         = 1'b0;
    d_ri_o          = 1'b0;
    d_ai_n_o        = 1'b1;
    d_j_n_o         = 1'b1;
    d_mi_n_o        = 1'b1;
    d_do_n_o        = 1'b1;
    d_ao_n_o        = 1'b1;
    d_bo_n_o        = 1'b1;
    d_co_n_o        = 1'b1;
    d_ro_n_o        = 1'b1;

    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d       = op_e'(cmd_op_i);
          addr_d     = cmd_addr_i;
          data_d     = cmd_data_i;
          cnt_d      = '0;
          rsp_data_d = 8'h00;
          rsp_err_d  = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        debug_request_o = 1'b1;
        // An ack arriving on the last allowed cycle still wins over the timeout.
        if (debug_ack_i) begin
          cnt_d   = '0;
          state_d = STEP1;
        end else if (cnt_q == ACK_TC) begin
          cnt_d     = '0;
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STEP1: begin
        debug_request_o = 1'b1;
        case (op_q)
          OP_WR_MEM, OP_RD_MEM: begin
            d_do_n_o     = 1'b0;
            d_mi_n_o     = 1'b0;
            debug_data_o = {4'h0, addr_q};
          end
          OP_SET_PC: begin
            d_do_n_o     = 1'b0;
            d_j_n_o      = 1'b0;
            debug_data_o = data_q;
          end
          OP_WR_A: begin
            d_do_n_o     = 1'b0;
            d_ai_n_o     = 1'b0;
            debug_data_o = data_q;
          end
          OP_RD_A: begin
            d_ao_n_o   = 1'b0;
            rsp_data_d = bus_i;
          end
          OP_RD_B: begin
            d_bo_n_o   = 1'b0;
            rsp_data_d = bus_i;
          end
          OP_RD_PC: begin
            d_co_n_o   = 1'b0;
            rsp_data_d = bus_i;
          end
          OP_CLR_CPU: d_clr_o = 1'b1;
          default: ;
        endcase
        if (op_q == OP_WR_MEM || op_q == OP_RD_MEM) state_d = STEP2;
        else                                        state_d = RELEASE;
      end
      STEP2: begin
        debug_request_o = 1'b1;
        if (op_q == OP_WR_MEM) begin
          d_do_n_o     = 1'b0;
          d_ri_o       = 1'b1;
          debug_data_o = data_q;
        end else begin
          d_ro_n_o   = 1'b0;
          rsp_data_d = bus_i;
        end
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!debug_ack_i) state_d = RSP;
      end
      RSP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes must drop the moment reset rises, not at the next edge.
    if (rst_i) begin
      debug_request_o = 1'b0;
      debug_data_o    = 8'h00;
      d_clr_o         = 1'b0;
      d_ri_o          = 1'b0;
      d_ai_n_o        = 1'b1;
      d_j_n_o         = 1'b1;
      d_mi_n_o        = 1'b1;
      d_do_n_o        = 1'b1;
      d_ao_n_o        = 1'b1;
      d_bo_n_o        = 1'b1;
      d_co_n_o        = 1'b1;
      d_ro_n_o        = 1'b1;
    end
  end

  assign d_hlt_o  = 1'b0;
  assign d_ce_o   = 1'b0;
  assign d_su_o   = 1'b0;
  assign d_bi_n_o = 1'b1;
  assign d_oi_n_o = 1'b1;
  assign d_ii_n_o = 1'b1;
  assign d_fi_n_o = 1'b1;
  assign d_io_n_o = 1'b1;
  assign d_eo_n_o = 1'b1;
  assign d_no_n_o = 1'b1;

  assign cmd_ready_o = (state_q == IDLE) && !rst_i;
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RSP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: a small core model answers the debug port, and an architectural
// model of RAM/A/B/PC predicts each response; fixed vectors, corner sequences, then random commands.
module tb_debug_sequencer;
  localparam int T_ACK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [7:0] rsp_data, debug_data, bus;
  logic       debug_request, debug_ack;
  logic d_clr, d_hlt, d_ce, d_su, d_ri;
  logic d_ai_n, d_bi_n, d_oi_n, d_ii_n, d_j_n, d_fi_n, d_mi_n, d_do_n;
  logic d_ao_n, d_bo_n, d_io_n, d_co_n, d_eo_n, d_ro_n, d_no_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debug_sequencer #(.ACK_TIMEOUT(T_ACK)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .busy_o(busy),
    .debug_request_o(debug_request), .debug_ack_i(debug_ack),
    .debug_data_o(debug_data), .bus_i(bus),
    .d_clr_o(d_clr), .d_hlt_o(d_hlt), .d_ce_o(d_ce), .d_su_o(d_su), .d_ri_o(d_ri),
    .d_ai_n_o(d_ai_n), .d_bi_n_o(d_bi_n), .d_oi_n_o(d_oi_n), .d_ii_n_o(d_ii_n),
    .d_j_n_o(d_j_n), .d_fi_n_o(d_fi_n), .d_mi_n_o(d_mi_n), .d_do_n_o(d_do_n),
    .d_ao_n_o(d_ao_n), .d_bo_n_o(d_bo_n), .d_io_n_o(d_io_n), .d_co_n_o(d_co_n),
    .d_eo_n_o(d_eo_n), .d_ro_n_o(d_ro_n), .d_no_n_o(d_no_n)
  );

  // ---------------- core model ----------------
  int         core_rise = 0, core_fall = 0;
  bit         core_never = 1'b0;
  logic       c_ack;
  int         c_rc, c_fc;
  logic [3:0] c_mar;
  logic [7:0] c_a, c_b, c_pc;
  logic [7:0] c_mem [16];

  assign debug_ack = c_ack;

  always_comb begin
    bus = 8'hEE;
    if (!d_do_n)      bus = debug_data;
    else if (!d_ro_n) bus = c_mem[c_mar];
    else if (!d_ao_n) bus = c_a;
    else if (!d_bo_n) bus = c_b;
    else if (!d_co_n) bus = c_pc;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_ack <= 1'b0; c_rc <= 0; c_fc <= 0; c_mar <= '0;
      c_a <= 8'h21; c_b <= 8'h42; c_pc <= 8'h00;
      for (int i = 0; i < 16; i++) c_mem[i] <= 8'(i * 17);
    end else begin
      if (core_never) c_ack <= 1'b0;
      else if (debug_request) begin
        c_fc <= 0;
        if (c_rc >= core_rise) c_ack <= 1'b1;
        c_rc <= c_rc + 1;
      end else begin
        c_rc <= 0;
        if (c_ack) begin
          if (c_fc >= core_fall) begin c_ack <= 1'b0; c_fc <= 0; end
          else c_fc <= c_fc + 1;
        end
      end
      if (!d_mi_n) c_mar <= bus[3:0];
      if (d_ri)    c_mem[c_mar] <= bus;
      if (!d_ai_n) c_a <= bus;
      if (!d_j_n)  c_pc <= bus;
      if (d_clr) begin c_a <= 8'h00; c_b <= 8'h00; c_pc <= 8'h00; end
    end
  end

  // ---------------- architectural reference ----------------
  logic [7:0] ref_mem [16];
  logic [7:0] ref_a, ref_b, ref_pc;

  task automatic ref_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 17);
    ref_a = 8'h21; ref_b = 8'h42; ref_pc = 8'h00;
  endtask

  task automatic ref_apply(input logic [2:0] op, input logic [3:0] addr, input logic [7:0] data,
                           output logic [7:0] r);
    r = 8'h00;
    case (op)
      3'd0: ref_mem[addr] = data;
      3'd1: r = ref_mem[addr];
      3'd2: ref_pc = data;
      3'd3: r = ref_a;
      3'd4: r = ref_b;
      3'd5: r = ref_pc;
      3'd6: ref_a = data;
      default: begin ref_a = 8'h00; ref_b = 8'h00; ref_pc = 8'h00; end
    endcase
  endtask

  // ---------------- control words ----------------
  typedef struct packed {
    logic clr, hlt, ce, su, ri;
    logic ai_n, bi_n, oi_n, ii_n, j_n, fi_n, mi_n, do_n, ao_n, bo_n, io_n, co_n, eo_n, ro_n, no_n;
    logic [7:0] dd;
  } cw_t;

  function automatic cw_t idle_cw();
    cw_t w;
    w = '1;
    w.clr = 1'b0; w.hlt = 1'b0; w.ce = 1'b0; w.su = 1'b0; w.ri = 1'b0; w.dd = 8'h00;
    return w;
  endfunction

  function automatic cw_t dut_cw();
    cw_t w;
    w = '{d_clr, d_hlt, d_ce, d_su, d_ri, d_ai_n, d_bi_n, d_oi_n, d_ii_n, d_j_n, d_fi_n,
          d_mi_n, d_do_n, d_ao_n, d_bo_n, d_io_n, d_co_n, d_eo_n, d_ro_n, d_no_n, debug_data};
    return w;
  endfunction

  function automatic void exp_words(input logic [2:0] op, input logic [3:0] addr,
                                    input logic [7:0] data, output cw_t w1, output cw_t w2,
                                    output int n);
    w1 = idle_cw(); w2 = idle_cw(); n = 1;
    case (op)
      3'd0: begin w1.do_n = 0; w1.mi_n = 0; w1.dd = {4'h0, addr};
                  w2.do_n = 0; w2.ri = 1; w2.dd = data; n = 2; end
      3'd1: begin w1.do_n = 0; w1.mi_n = 0; w1.dd = {4'h0, addr}; w2.ro_n = 0; n = 2; end
      3'd2: begin w1.do_n = 0; w1.j_n = 0; w1.dd = data; end
      3'd3: w1.ao_n = 0;
      3'd4: w1.bo_n = 0;
      3'd5: w1.co_n = 0;
      3'd6: begin w1.do_n = 0; w1.ai_n = 0; w1.dd = data; end
      default: w1.clr = 1;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one command, watch it through to the response and consume it.
  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [3:0] addr,
                         input logic [7:0] data, input logic [7:0] exp_d, input logic exp_e,
                         input int exp_lat, input int rise, input int fall, input bit never,
                         input int wait_n, input bit pre, input bit hold_next);
    cw_t e1, e2, w;
    cw_t seen[$];
    int  ne, n, lat;
    if (never) begin e1 = idle_cw(); e2 = idle_cw(); ne = 0; end
    else exp_words(op, addr, data, e1, e2, ne);
    core_rise = rise; core_fall = fall; core_never = never;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; rsp_ready = pre;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'($urandom); cmd_addr = 4'($urandom); cmd_data = 8'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      w = dut_cw();
      if (w != idle_cw()) seen.push_back(w);
      if (lat == 1) chk({tag, " no_pipeline"}, 32'(cmd_ready), 32'd0);
    end while (!rsp_valid && lat < 500);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " rsp_data"}, 32'(rsp_data), 32'(exp_d));
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(exp_e));
    chk({tag, " req_in_rsp"}, 32'(debug_request), 32'd0);
    chk({tag, " strobe_cycles"}, 32'(seen.size()), 32'(ne));
    if (ne >= 1 && seen.size() >= 1) chk({tag, " word1"}, {4'h0, seen[0]}, {4'h0, e1});
    if (ne == 2 && seen.size() >= 2) chk({tag, " word2"}, {4'h0, seen[1]}, {4'h0, e2});

    if (pre) begin
      @(negedge clk);
      chk({tag, " pulse_end"}, {30'd0, rsp_valid, cmd_ready}, 32'h1);
      chk({tag, " data_kept"}, 32'(rsp_data), 32'(exp_d));
      rsp_ready = 1'b0;
    end else begin
      for (int i = 0; i < wait_n; i++) begin
        if (hold_next) begin
          cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = 4'h0; cmd_data = 8'h00;
        end
        @(negedge clk);
        chk({tag, " hold"}, {22'd0, rsp_valid, cmd_ready, debug_request, rsp_err, rsp_data},
            {22'd0, 1'b1, 1'b0, 1'b0, exp_e, exp_d});
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_d;
    int         exp_lat;
    bit         pre;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    vec_t       vecs[12];
    logic [7:0] r, ed;
    logic [2:0] op;
    logic [3:0] addr;
    logic [7:0] data;
    bit         found, never, pre;
    int         n, rise, fall, wt, el;
    cw_t        w;

    vecs = '{
      '{3'd0, 4'hA, 8'h5C, 8'h00, 7, 1'b0},
      '{3'd1, 4'hA, 8'h00, 8'h5C, 7, 1'b1},
      '{3'd1, 4'h3, 8'h99, 8'h33, 7, 1'b0},
      '{3'd2, 4'h0, 8'h03, 8'h00, 6, 1'b0},
      '{3'd5, 4'h0, 8'h00, 8'h03, 6, 1'b1},
      '{3'd4, 4'h0, 8'h00, 8'h42, 6, 1'b0},
      '{3'd6, 4'h0, 8'h7E, 8'h00, 6, 1'b1},
      '{3'd3, 4'h0, 8'h00, 8'h7E, 6, 1'b0},
      '{3'd7, 4'h0, 8'h00, 8'h00, 6, 1'b0},
      '{3'd3, 4'h0, 8'h00, 8'h00, 6, 1'b1},
      '{3'd5, 4'h0, 8'h00, 8'h00, 6, 1'b0},
      '{3'd4, 4'h0, 8'h00, 8'h00, 6, 1'b0}
    };
    ref_reset();

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_word", {4'h0, dut_cw()}, {4'h0, idle_cw()});
    chk("reset_flags", {28'd0, rsp_valid, rsp_err, busy, debug_request}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);

    // fixed vectors
    for (int i = 0; i < 12; i++) begin
      ref_apply(vecs[i].op, vecs[i].addr, vecs[i].data, r);
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp_d,
              1'b0, vecs[i].exp_lat, 0, 0, 1'b0, 1, vecs[i].pre, 1'b0);
    end

    // reset in the middle of WR_MEM STEP2
    core_rise = 0; core_fall = 0; core_never = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 4'hA; cmd_data = 8'hC3;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    found = 1'b0; n = 0;
    while (n < 20 && !found) begin
      @(negedge clk); n++;
      w = dut_cw();
      if (w.ri) found = 1'b1;
    end
    chk("rst_step2_cycle", 32'(n), 32'd4);
    rst = 1'b1;
    #1;
    chk("rst_word", {4'h0, dut_cw()}, {4'h0, idle_cw()});
    chk("rst_req_busy", {30'd0, debug_request, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_reset();
    @(negedge clk);
    chk("rst_after", {29'd0, cmd_ready, rsp_valid, rsp_err}, 32'h4);

    // ack never arrives
    run_cmd("timeout", 3'd3, 4'h0, 8'h00, 8'h00, 1'b1, T_ACK + 1, 0, 0, 1'b1, 2, 1'b0, 1'b0);

    // ack falls three cycles late
    ref_apply(3'd2, 4'h0, 8'h07, r);
    run_cmd("set_pc_slow", 3'd2, 4'h0, 8'h07, r, 1'b0, 9, 0, 3, 1'b0, 1, 1'b0, 1'b0);

    // response held for 10 cycles with the next command waiting
    ref_apply(3'd3, 4'h0, 8'h00, r);
    run_cmd("rd_a_hold", 3'd3, 4'h0, 8'h00, r, 1'b0, 6, 0, 0, 1'b0, 10, 1'b0, 1'b1);
    ref_apply(3'd5, 4'h0, 8'h00, r);
    run_cmd("rd_pc_next", 3'd5, 4'h0, 8'h00, r, 1'b0, 6, 0, 0, 1'b0, 0, 1'b0, 1'b0);

    // random commands against the reference
    for (int k = 0; k < 40; k++) begin
      op    = 3'($urandom_range(0, 7));
      addr  = 4'($urandom);
      data  = 8'($urandom);
      never = ($urandom_range(0, 9) == 0);
      rise  = int'($urandom_range(0, 1));
      fall  = int'($urandom_range(0, 3));
      wt    = int'($urandom_range(0, 3));
      pre   = 1'($urandom_range(0, 1));
      if (never) begin
        ed = 8'h00; el = T_ACK + 1;
      end else begin
        ref_apply(op, addr, data, ed);
        el = 5 + rise + ((op <= 3'd1) ? 2 : 1) + fall;
      end
      run_cmd($sformatf("rnd%0d", k), op, addr, data, ed, never, el, rise, fall, never,
              wt, pre, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
